// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Round-robin arbiter sharing one WIDTH-bit unsigned adder between NREQ
// requesters. The granted requester's operand pair is summed (with carry) and
// captured in a single-entry result register that is held until the consumer
// accepts it. A drain and a new grant may happen in the same cycle, so the
// block sustains one result per cycle while res_ready stays high.
//
// Optional feature (compile-time macro):
//   ADDER_ARB_SAT_EN  defined   -> saturating add (sum = all ones on carry)
//                     undefined -> wrapping add
//
// Ports:
//   clk        in   design clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        requester i presents operands
//   req_ready  out  [NREQ]        requester i accepted this cycle (combinational)
//   req_a      in   [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NREQ*WIDTH]  operand B, same packing
//   res_valid  out                result register holds a valid result
//   res_ready  in                 consumer accepts the result
//   res_sum    out  [WIDTH]       result value
//   res_carry  out                carry-out of the unsigned add
//   res_id     out  [IDW]         index of the requester that produced it
// -----------------------------------------------------------------------------
module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WIDTH-1:0]        res_sum,
    output logic                    res_carry,
    output logic [IDW-1:0]          res_id
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDW-1:0]   r_id;

    logic             w_slot_free;
    logic             w_grant;
    logic [IDW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_result;

    // {carry, sum} of an unsigned add; the sum saturates when the feature is on.
    function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ADDER_ARB_SAT_EN
        if (s[WIDTH]) begin
            s[WIDTH-1:0] = '1;
        end
`endif
        return s;
    endfunction

    // Round-robin search starting at r_ptr. rst_n gates the grant so nothing
    // is accepted while reset is held, even though the slot reads as free.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant     = 1'b0;
        w_gnt_idx   = '0;
        w_ready     = '0;
        w_a         = '0;
        w_b         = '0;
        w_slot_free = (r_state == S_EMPTY) || res_ready;
        if (rst_n && w_slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_grant) begin
                    idx = int'(r_ptr) + k;
                    if (idx >= NREQ) begin
                        idx = idx - NREQ;
                    end
                    if (req_valid[idx]) begin
                        w_grant      = 1'b1;
                        w_gnt_idx    = IDW'(idx);
                        w_ready[idx] = 1'b1;
                        w_a          = req_a[idx*WIDTH +: WIDTH];
                        w_b          = req_b[idx*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    assign w_result  = add_op(w_a, w_b);
    assign req_ready = w_ready;

    // Output-register state: a grant always fills; a drain alone empties.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_grant) begin
                    w_state_nxt = S_FULL;
                end else if (res_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_sum   <= w_result[WIDTH-1:0];
                r_carry <= w_result[WIDTH];
                r_id    <= w_gnt_idx;
                r_ptr   <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign res_valid = (r_state == S_FULL);
    assign res_sum   = r_sum;
    assign res_carry = r_carry;
    assign res_id    = r_id;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_carry;
    logic [1:0]            res_id;

    int errors = 0;
    int checks = 0;

    // Reference model: result register contents and round-robin pointer.
    int m_ptr   = 0;
    int m_valid = 0;
    int m_sum   = 0;
    int m_carry = 0;
    int m_id    = 0;

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    // Which requester the rules say is granted right now (-1 for none).
    function automatic int exp_grant();
        int i;
        if (!rst_n) return -1;
        if (m_valid != 0 && !res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        logic [NREQ-1:0] r;
        g = exp_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [11:0] exp_out();
        return {m_valid[0], m_sum[7:0], m_carry[0], m_id[1:0]};
    endfunction

    task automatic set_lane(input int i, input int a, input int b);
        req_a[i*WIDTH +: WIDTH] = a[7:0];
        req_b[i*WIDTH +: WIDTH] = b[7:0];
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0;
    endtask

    // One clock edge; the model follows the same inputs the DUT sees.
    task automatic tick();
        int g, a, b, t;
        g = exp_grant();
        @(posedge clk);
        if (g >= 0) begin
            a = int'(req_a[g*WIDTH +: WIDTH]);
            b = int'(req_b[g*WIDTH +: WIDTH]);
            t = a + b;
            m_carry = (t >= 256) ? 1 : 0;
            m_sum = t % 256;
`ifdef ADDER_ARB_SAT_EN
            if (m_carry == 1) m_sum = 255;
`endif
            m_id = g;
            m_valid = 1;
            m_ptr = (g + 1) % NREQ;
        end else if (res_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        #2;
        checks++;
        if ({res_valid, res_sum, res_carry, res_id} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 000", {res_valid, res_sum, res_carry, res_id});
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        req_valid = '0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        res_ready = 1'b1;
        set_lane(2, 'h12, 'h34);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({res_valid, res_sum, res_carry, res_id} !== {1'b1, 8'h46, 1'b0, 2'd2}) begin
            errors++;
            $display("FAIL single_result: got v=%b s=%h c=%b id=%0d want v=1 s=46 c=0 id=2",
                     res_valid, res_sum, res_carry, res_id);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        res_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) set_lane(i, $urandom_range(255), $urandom_range(255));
            #1;
            tick();
            checks++;
            if (res_id !== 2'(k % NREQ) || !res_valid || exp_out() !== {res_valid, res_sum, res_carry, res_id}) begin
                errors++;
                $display("FAIL rr_order[%0d]: got id=%0d out=%h want id=%0d out=%h",
                         k, res_id, {res_valid, res_sum, res_carry, res_id}, k % NREQ, exp_out());
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_carry();
        logic [7:0] want;
`ifdef ADDER_ARB_SAT_EN
        want = 8'hFF;
`else
        want = 8'h10;
`endif
        do_reset();
        res_ready = 1'b1;
        set_lane(0, 'hF0, 'h20);
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = '0;
        checks++;
        if (res_carry !== 1'b1 || res_sum !== want || res_id !== 2'd0) begin
            errors++;
            $display("FAIL carry: got s=%h c=%b id=%0d want s=%h c=1 id=0", res_sum, res_carry, res_id, want);
        end
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_lane(i, 16 * i + 1, 3 * i + 2);
        req_valid = '1;
        #1;
        tick();
        for (int k = 0; k < 5; k++) begin
            set_lane(k % NREQ, $urandom_range(255), $urandom_range(255));
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL hold_ready[%0d]: got %b want 0000", k, req_ready);
            end
            tick();
            checks++;
            if ({res_valid, res_sum, res_carry, res_id} !== {1'b1, 8'h03, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got %h want %h", k,
                         {res_valid, res_sum, res_carry, res_id}, {1'b1, 8'h03, 1'b0, 2'd0});
            end
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL hold_release_ready: got %b want 0010", req_ready);
        end
        tick();
        checks++;
        if (!res_valid || res_id !== 2'd1 || exp_out() !== {res_valid, res_sum, res_carry, res_id}) begin
            errors++;
            $display("FAIL hold_refill: got %h want %h", {res_valid, res_sum, res_carry, res_id}, exp_out());
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        set_lane(1, 'h55, 'h22);
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({res_valid, res_sum, res_carry, res_id} !== 12'h000 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: got out=%h ready=%b want out=000 ready=0000",
                     {res_valid, res_sum, res_carry, res_id}, req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got res_valid=%b want 0", res_valid);
        end
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        tick();
        checks++;
        if (res_id !== 2'd0 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: got id=%0d v=%b want id=0 v=1", res_id, res_valid);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_ptr_skip();
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = 4'b1010;
        #1;
        tick();
        checks++;
        if (res_id !== 2'd3) begin
            errors++;
            $display("FAIL skip_first: got id=%0d want 3", res_id);
        end
        tick();
        checks++;
        if (res_id !== 2'd1) begin
            errors++;
            $display("FAIL skip_second: got id=%0d want 1", res_id);
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL skip_ptr: got ready=%b want 0100", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            req_valid = 4'($urandom_range(15));
            res_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NREQ; i++) set_lane(i, $urandom_range(255), $urandom_range(255));
            #1;
            er = exp_ready();
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", k, req_ready, er);
            end
            tick();
            checks++;
            if ({res_valid, res_sum, res_carry, res_id} !== exp_out()) begin
                errors++;
                $display("FAIL rand_out[%0d]: got %h want %h", k, {res_valid, res_sum, res_carry, res_id}, exp_out());
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_carry();
        test_hold();
        test_reset_mid();
        test_ptr_skip();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
